// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
package seg_scan_pkg;

  // Active-low segment patterns that are not digit encodings
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Bit positions inside the {g,f,e,d,c,b,a} segment vector
  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  // Digit slot index, 0 = rightmost digit
  typedef logic [1:0] slot_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low seven-segment pattern; non-BCD nibbles show a dash.
module bcd_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup of the segment pattern for one nibble
  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'd0:    o_seg = 7'h40;
      4'd1:    o_seg = 7'h79;
      4'd2:    o_seg = 7'h24;
      4'd3:    o_seg = 7'h30;
      4'd4:    o_seg = 7'h19;
      4'd5:    o_seg = 7'h12;
      4'd6:    o_seg = 7'h02;
      4'd7:    o_seg = 7'h78;
      4'd8:    o_seg = 7'h00;
      4'd9:    o_seg = 7'h10;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller. New scores are held in a shadow
// register and copied to the displayed register only at the frame wrap.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] digits_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  slot_t         r_slot;
  logic [15:0]   r_active;
  logic [15:0]   r_shadow;
  logic          r_pending;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_start;

  logic          w_tick;
  logic          w_wrap;
  logic          w_accept;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg_enc;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;
  logic          w_dp_next;

  assign w_tick     = (r_presc == PRE_TERM);
  assign w_wrap     = w_tick & (r_slot == 2'd3);
  assign w_accept   = load_valid & ~r_pending;
  assign load_ready = ~r_pending;

  // Prescaler and digit slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_slot  <= 2'd0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_slot  <= r_slot + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Load handshake into the shadow register and transfer at the frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= 16'h0000;
      r_active  <= 16'h0000;
      r_pending <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_active <= r_shadow;
      end
      if (w_accept) begin
        // A load taken in the wrap cycle waits for the next wrap
        r_shadow  <= digits_in;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Select the nibble and anode for the current slot
  always_comb begin
    w_nibble  = r_active[3:0];
    w_an_next = 4'b0001;
    case (r_slot)
      2'd0: begin w_nibble = r_active[3:0];   w_an_next = 4'b0001; end
      2'd1: begin w_nibble = r_active[7:4];   w_an_next = 4'b0010; end
      2'd2: begin w_nibble = r_active[11:8];  w_an_next = 4'b0100; end
      2'd3: begin w_nibble = r_active[15:12]; w_an_next = 4'b1000; end
      default: begin w_nibble = r_active[3:0]; w_an_next = 4'b0001; end
    endcase
  end

  bcd_to_seg7 u_enc (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_enc)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_blank;

  // Blank a digit when it and every higher digit are zero; digit 0 always shows
  always_comb begin
    w_blank = 1'b0;
    case (r_slot)
      2'd3:    w_blank = (r_active[15:12] == 4'h0);
      2'd2:    w_blank = (r_active[15:8]  == 8'h00);
      2'd1:    w_blank = (r_active[15:4]  == 12'h000);
      default: w_blank = 1'b0;
    endcase
  end

  assign w_seg_next = w_blank ? SEG_BLANK : w_seg_enc;
`else
  assign w_seg_next = w_seg_enc;
`endif

  assign w_dp_next = (r_slot == 2'd1) ? 1'b0 : 1'b1;

  // Registered display outputs and frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an          <= 4'b0000;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_an_next;
      r_seg         <= w_seg_next;
      r_dp          <= w_dp_next;
      r_frame_start <= w_wrap;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=4 and an expected-frame queue.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] digits_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  seg_scan_ctrl #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digits_in   (digits_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the four expected slot entries for a frame showing value v
  task automatic push_frame(input logic [15:0] v);
    exp_t e;
    logic [3:0] nib;
    logic       lead_zero;
    lead_zero = 1'b1;
    for (int s = 3; s >= 0; s--) begin
      nib  = v[s*4 +: 4];
      e.an = 4'b0001 << s;
      e.dp = (s == 1) ? 1'b0 : 1'b1;
      e.seg = enc(nib);
      if (nib != 4'h0) lead_zero = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (lead_zero && s != 0) e.seg = 7'h7F;
`endif
      q.push_front(e);
    end
  endtask

  // Check one frame (16 cycles) aligned to the slot-0 phase, with an optional load
  task automatic run_frame(input bit do_load, input logic [15:0] val, input int load_at,
                           input logic exp_rdy_load, input logic exp_rdy_end);
    exp_t e;
    int   c;
    for (int s = 0; s < 4; s++) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty observed=0 expected=entry");
        e = '0;
      end else begin
        e = q.pop_front();
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); #1;
        c = s * 4 + k + 1;
        chk($sformatf("an_s%0d", s), {12'h000, an}, {12'h000, e.an});
        chk($sformatf("seg_s%0d", s), {9'h000, seg}, {9'h000, e.seg});
        chk($sformatf("dp_s%0d", s), {15'h0000, dp}, {15'h0000, e.dp});
        if (c < 16) chk("frame_start_low", {15'h0000, frame_start}, 16'h0000);
        if (do_load && c == load_at + 1) begin
          chk("ready_after_load", {15'h0000, load_ready}, {15'h0000, exp_rdy_load});
          load_valid = 1'b0;
        end
        if (do_load && c == load_at) begin
          load_valid = 1'b1;
          digits_in  = val;
        end
      end
    end
    chk("frame_start_pulse", {15'h0000, frame_start}, 16'h0001);
    chk("ready_frame_end", {15'h0000, load_ready}, {15'h0000, exp_rdy_end});
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    digits_in  = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_an", {12'h000, an}, 16'h0000);
    chk("rst_seg", {9'h000, seg}, 16'h007F);
    chk("rst_dp", {15'h0000, dp}, 16'h0001);
    chk("rst_ready", {15'h0000, load_ready}, 16'h0001);
    chk("rst_fs", {15'h0000, frame_start}, 16'h0000);
    rst_n = 1'b1;

    // Frame 1: blank score, load 1234 mid-frame
    push_frame(16'h0000);
    run_frame(1'b1, 16'h1234, 6, 1'b0, 1'b1);
    // Frame 2: 1234 shown, load 0009 in the wrap cycle
    push_frame(16'h1234);
    run_frame(1'b1, 16'h0009, 15, 1'b0, 1'b0);
    // Frame 3: still 1234, back-pressured 5555 is ignored
    push_frame(16'h1234);
    run_frame(1'b1, 16'h5555, 3, 1'b0, 1'b1);
    // Frame 4: 0009 shown, load invalid BCD
    push_frame(16'h0009);
    run_frame(1'b1, 16'hAF00, 2, 1'b0, 1'b1);
    // Frame 5: AF00 shown, load 0042
    push_frame(16'hAF00);
    run_frame(1'b1, 16'h0042, 2, 1'b0, 1'b1);
    // Frame 6: 0042 shown
    push_frame(16'h0042);
    run_frame(1'b0, 16'h0000, 0, 1'b1, 1'b1);

    // Mid-frame reset with a pending load
    repeat (5) @(negedge clk);
    #1;
    load_valid = 1'b1;
    digits_in  = 16'h7777;
    @(negedge clk); #1;
    load_valid = 1'b0;
    chk("ready_pending", {15'h0000, load_ready}, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk("midrst_an", {12'h000, an}, 16'h0000);
    chk("midrst_seg", {9'h000, seg}, 16'h007F);
    chk("midrst_dp", {15'h0000, dp}, 16'h0001);
    chk("midrst_ready", {15'h0000, load_ready}, 16'h0001);
    chk("midrst_fs", {15'h0000, frame_start}, 16'h0000);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(16'h0000);
    run_frame(1'b0, 16'h0000, 0, 1'b1, 1'b1);
    push_frame(16'h0000);
    run_frame(1'b0, 16'h0000, 0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
